dmem_arbiter: RTL and testbench

Shares the single synchronous-read data RAM between two requesters. Port 0 is the MEM stage load/store path; port 1 is the debug/display memory port.
Fixed priority goes to port 0. A starvation counter guarantees port 1 forward progress.
The RAM has 1-cycle read latency. The block issues one access per cycle, fully pipelined, and routes the returned read data to the requester that issued the read.

---
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : two-port fixed-priority arbiter for the synchronous data RAM
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wen,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wen,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic        ram_en,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,

    output logic        m1_starving
);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_BOOST  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_vld_q, rd_vld_d;
    logic             rd_owner_q, rd_owner_d;

    logic             win0, win1, any_win;
    logic [3:0]       sel_wen;

    // Ungated winners feed next-state logic; reset gating is applied only at the outputs.
    always_comb begin
        win1    = m1_req & ((state_q == ST_BOOST) | ~m0_req);
        win0    = m0_req & ~win1;
        any_win = win0 | win1;
        sel_wen = win1 ? m1_wen : m0_wen;
    end

    assign m0_gnt    = win0 & resetn;
    assign m1_gnt    = win1 & resetn;
    assign ram_en    = any_win & resetn;
    assign ram_addr  = win1 ? m1_addr  : m0_addr;
    assign ram_wdata = win1 ? m1_wdata : m0_wdata;
    assign ram_wen   = (any_win & resetn) ? sel_wen : 4'b0000;

    always_comb begin
        rd_vld_d   = any_win & (sel_wen == 4'b0000);
        rd_owner_d = win1;

        if (!m1_req || win1) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        state_d = state_q;
        case (state_q)
            ST_NORMAL: if (cnt_d >= CNT_LIMIT)  state_d = ST_BOOST;
            ST_BOOST:  if (win1 || !m1_req)     state_d = ST_NORMAL;
            default:                            state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_NORMAL;
            cnt_q      <= '0;
            rd_vld_q   <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_vld_q   <= rd_vld_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign m0_rvalid   = rd_vld_q & ~rd_owner_q;
    assign m1_rvalid   = rd_vld_q &  rd_owner_q;
    assign m0_rdata    = m0_rvalid ? ram_rdata : 32'h0;
    assign m1_rdata    = m1_rvalid ? ram_rdata : 32'h0;
    assign m1_starving = (state_q == ST_BOOST);

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : directed + random bench for dmem_arbiter against a reference model
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_wen = '0, m1_wen = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_en, m1_starving;
    logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata;
    logic [3:0]  ram_wen;
    logic [31:0] ram_rdata;

    dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .m1_starving(m1_starving)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : ((32'(i) * 32'h01010101) ^ 32'h5A5A0000);
    endfunction

    // Synchronous-read RAM behind the arbiter
    logic [31:0] ram_mem [256];
    logic        ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
            ram_init <= 1'b1;
        end else if (ram_en) begin
            if (ram_wen == 4'b0000) begin
                ram_rdata <= ram_mem[ram_addr[9:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_wen[b]) ram_mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end
    end

    // Reference model state
    logic [31:0] gmem [256];
    int          denied = 0;
    logic        pend_v = 1'b0, pend_p = 1'b0;
    logic [31:0] pend_d = '0;
    logic        exp_g0, exp_g1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic rn, input logic mid,
                        input logic r0, input logic [31:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                        input logic r1, input logic [31:0] a1, input logic [3:0] w1, input logic [31:0] d1);
        logic        boost, e0, e1, ev0, ev1;
        logic [31:0] sa, sd;
        logic [3:0]  sw;
        @(posedge clk);
        #1;
        resetn = rn;
        if (!rn) begin
            pend_v = 1'b0;
            denied = 0;
        end
        m0_req = r0; m0_addr = a0; m0_wen = w0; m0_wdata = d0;
        m1_req = r1; m1_addr = a1; m1_wen = w1; m1_wdata = d1;
        #1;
        boost = (denied >= STARVE_LIMIT);
        e1    = rn && r1 && (boost || !r0);
        e0    = rn && r0 && !e1;
        ev0   = pend_v && !pend_p;
        ev1   = pend_v &&  pend_p;
        chk("m0_gnt",    32'(m0_gnt),    32'(e0));
        chk("m1_gnt",    32'(m1_gnt),    32'(e1));
        chk("ram_en",    32'(ram_en),    32'(e0 | e1));
        chk("ram_addr",  ram_addr,       e1 ? a1 : a0);
        chk("ram_wdata", ram_wdata,      e1 ? d1 : d0);
        chk("ram_wen",   32'(ram_wen),   32'(e1 ? w1 : (e0 ? w0 : 4'b0000)));
        chk("starving",  32'(m1_starving), 32'(boost));
        chk("m0_rvalid", 32'(m0_rvalid), 32'(ev0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(ev1));
        chk("m0_rdata",  m0_rdata,       ev0 ? pend_d : 32'h0);
        chk("m1_rdata",  m1_rdata,       ev1 ? pend_d : 32'h0);
        exp_g0 = e0;
        exp_g1 = e1;

        // Advance the model to the state after the coming edge
        pend_v = 1'b0;
        if (e0 || e1) begin
            sa = e1 ? a1 : a0;
            sw = e1 ? w1 : w0;
            sd = e1 ? d1 : d0;
            if (sw == 4'b0000) begin
                pend_v = 1'b1;
                pend_p = e1;
                pend_d = gmem[sa[9:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (sw[b]) gmem[sa[9:2]][b*8 +: 8] = sd[b*8 +: 8];
            end
        end
        if (rn && r1 && !e1) denied++;
        else                 denied = 0;

        if (mid) begin
            #2;
            resetn = 1'b0;
            pend_v = 1'b0;
            denied = 0;
        end
    endtask

    task automatic idle(input logic rn);
        step(rn, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    logic        q0v = 1'b0, q1v = 1'b0;
    logic [31:0] q0a, q0d, q1a, q1d;
    logic [3:0]  q0w, q1w;

    initial begin
        for (int i = 0; i < 256; i++) gmem[i] = init_word(i);

        // Requests raised during reset must see no grant
        step(1'b0, 1'b0, 1'b1, 32'h10, 4'h0, 32'h0, 1'b1, 32'h14, 4'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h10, 4'h0, 32'h0, 1'b1, 32'h14, 4'h0, 32'h0);
        idle(1'b1);

        // Port 0 single read of 0x10
        step(1'b1, 1'b0, 1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        idle(1'b1);
        chk("rd10_data", m0_rdata, 32'hDEADBEEF);

        // Alternating owners
        step(1'b1, 1'b0, 1'b1, 32'h20, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h24, 4'h0, 32'h0);
        idle(1'b1);

        // Byte-lane write then read back
        step(1'b1, 1'b0, 1'b1, 32'h31, 4'b0100, 32'h00AB0000, 1'b0, 32'h0, 4'h0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h30, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        idle(1'b1);
        chk("wr_byte2", 32'(m0_rdata[23:16]), 32'hAB);
        idle(1'b1);

        // Continuous contention: port 1 forced through every fifth cycle
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 1'b1, 32'h40 + 32'(k*4), 4'h0, 32'h0, 1'b1, 32'h80, 4'h0, 32'h0);
            chk("starve_g1", 32'(m1_gnt), 32'(k == 4 || k == 9));
            chk("starve_st", 32'(m1_starving), 32'(k == 4 || k == 9));
        end

        // Port 1 withdraws while boosted
        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b0, 1'b1, 32'h50, 4'h0, 32'h0, 1'b1, 32'h84, 4'h0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h54, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("drop_st", 32'(m1_starving), 32'h1);
        chk("drop_g0", 32'(m0_gnt), 32'h1);
        idle(1'b1);
        chk("drop_norm", 32'(m1_starving), 32'h0);

        // Reset asserted inside the cycle of a granted port-1 read
        step(1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h60, 4'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h64, 4'h0, 32'h0, 1'b1, 32'h60, 4'h0, 32'h0);
        idle(1'b1);
        chk("rst_rv1", 32'(m1_rvalid), 32'h0);

        // Randomized traffic with held requests
        for (int c = 0; c < 600; c++) begin
            if (!q0v) begin
                q0v = ($urandom_range(3, 0) != 0);
                q0a = $urandom;
                q0w = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
                q0d = $urandom;
            end
            if (!q1v) begin
                q1v = ($urandom_range(1, 0) != 0);
                q1a = $urandom;
                q1w = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
                q1d = $urandom;
            end else if ($urandom_range(15, 0) == 0) begin
                q1v = 1'b0;
            end
            step(1'b1, 1'b0, q0v, q0a, q0w, q0d, q1v, q1a, q1w, q1d);
            if (exp_g0) q0v = 1'b0;
            if (exp_g1) q1v = 1'b0;
        end
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
